// File: rtl/usb_cmd_pkg.sv
// Shared opcodes, FSM encoding and constants for the USB command bridge.
package usb_cmd_pkg;

  localparam logic [1:0] OP_WB_WR  = 2'b00;
  localparam logic [1:0] OP_WB_RD  = 2'b01;
  localparam logic [1:0] OP_LOC_WR = 2'b10;
  localparam logic [1:0] OP_LOC_RD = 2'b11;

  localparam logic [7:0] READ_ERR_BYTE = 8'hEE;

  typedef enum logic [3:0] {
    StIdle,
    StFetchA,
    StFetchD,
    StExec,
    StWbWait,
    StWrIn,
    StNext,
    StArm,
    StCommit
  } state_e;

  function automatic logic is_wb_op(input logic [1:0] op);
    return ~op[1];
  endfunction

endpackage

// File: rtl/usb_cmd_wb_master.sv
// Single-transfer wishbone master: start/done handshake with a bounded wait for ack.
module usb_cmd_wb_master
  import usb_cmd_pkg::*;
#(
  parameter int unsigned WB_ADR_W   = 3,
  parameter int unsigned WB_TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  input  logic                we_i,
  input  logic [WB_ADR_W-1:0] adr_i,
  input  logic [7:0]          wdat_i,
  output logic                done_o,
  output logic                timeout_o,
  output logic [7:0]          rdata_o,
  output logic [WB_ADR_W-1:0] wb_adr_o,
  output logic [7:0]          wb_dat_o,
  input  logic [7:0]          wb_dat_i,
  output logic                wb_we_o,
  output logic                wb_stb_o,
  input  logic                wb_ack_i
);

  localparam int unsigned CntW = (WB_TIMEOUT > 1) ? $clog2(WB_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WB_TIMEOUT - 1);

  logic                stb_q, stb_d;
  logic                we_q, we_d;
  logic [WB_ADR_W-1:0] adr_q, adr_d;
  logic [7:0]          dat_q, dat_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                tmo_q, tmo_d;
  logic [7:0]          rdata_q, rdata_d;

  always_comb begin
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    rdata_d = rdata_q;
    if (stb_q) begin
      if (wb_ack_i) begin
        stb_d   = 1'b0;
        we_d    = 1'b0;
        done_d  = 1'b1;
        rdata_d = wb_dat_i;
      end else if (cnt_q == CntLast) begin
        // Slave never answered: release the bus and report a poisoned byte.
        stb_d   = 1'b0;
        we_d    = 1'b0;
        done_d  = 1'b1;
        tmo_d   = 1'b1;
        rdata_d = READ_ERR_BYTE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (start_i) begin
      stb_d = 1'b1;
      we_d  = we_i;
      adr_d = adr_i;
      dat_d = wdat_i;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
    end
  end

  assign wb_stb_o  = stb_q;
  assign wb_we_o   = we_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign done_o    = done_q;
  assign timeout_o = tmo_q;
  assign rdata_o   = rdata_q;

endmodule

// File: rtl/usb_cmd_bridge.sv
// Command engine: executes (address, data) pairs from an OUT packet against local
// registers or wishbone, gathers read results into one IN packet committed after re-arm.
module usb_cmd_bridge
  import usb_cmd_pkg::*;
#(
  parameter int unsigned             NUM_REGS   = 8,
  parameter logic [8*NUM_REGS-1:0]   REG_INIT   = {NUM_REGS{8'h00}},
  parameter int unsigned             WB_ADR_W   = 3,
  parameter int unsigned             OUT_ADDR_W = 9,
  parameter int unsigned             IN_ADDR_W  = 9,
  parameter int unsigned             RD_LAT     = 4,
  parameter int unsigned             WB_TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    buf_out_hasdata,
  input  logic [OUT_ADDR_W:0]     buf_out_len,
  input  logic [7:0]              buf_out_q,
  output logic [OUT_ADDR_W-1:0]   buf_out_addr,
  output logic                    buf_out_arm,
  input  logic                    buf_out_arm_ack,
  output logic [IN_ADDR_W-1:0]    buf_in_addr,
  output logic [7:0]              buf_in_data,
  output logic                    buf_in_wren,
  output logic                    buf_in_commit,
  output logic [IN_ADDR_W:0]      buf_in_commit_len,
  input  logic                    buf_in_commit_ack,
  output logic [WB_ADR_W-1:0]     wb_adr_o,
  output logic [7:0]              wb_dat_o,
  input  logic [7:0]              wb_dat_i,
  output logic                    wb_we_o,
  output logic                    wb_stb_o,
  input  logic                    wb_ack_i,
  output logic [8*NUM_REGS-1:0]   regs_out,
  output logic                    busy,
  output logic [2:0]              err_flags
);

  localparam int unsigned LatW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LatW-1:0] LatLast = LatW'(RD_LAT - 1);

  state_e                        state_q, state_d;
  logic [OUT_ADDR_W-1:0]         pair_q, pair_d;
  logic [OUT_ADDR_W-1:0]         npairs_q, npairs_d;
  logic [LatW-1:0]               lat_q, lat_d;
  logic [7:0]                    a_q, a_d;
  logic [7:0]                    d_q, d_d;
  logic [7:0]                    rdat_q, rdat_d;
  logic [IN_ADDR_W:0]            rcount_q, rcount_d;
  logic [2:0]                    err_q, err_d;
  logic [NUM_REGS-1:0][7:0]      regs_q, regs_d;
  logic [2:0]                    ack_sync_q;

  logic                          ack_rise;
  logic [1:0]                    op;
  logic [4:0]                    idx;
  logic                          idx_ok;
  logic [7:0]                    loc_val;
  logic [OUT_ADDR_W:0]           ptr_full;
  logic                          wb_start, wb_we, wb_done, wb_tmo;
  logic [7:0]                    wb_rdata;
  logic                          unused_bits;

  assign op       = a_q[7:6];
  assign idx      = a_q[4:0];
  assign idx_ok   = {27'd0, idx} < NUM_REGS;
  assign ack_rise = ack_sync_q[1] & ~ack_sync_q[2];
  // Byte pointer is twice the pair index; odd byte is the data half.
  assign ptr_full = {pair_q, (state_q == StFetchD)};
  assign unused_bits = ^{a_q[5], buf_out_len[0]};

  always_comb begin
    loc_val = READ_ERR_BYTE;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == 5'(i)) loc_val = regs_q[i];
    end
  end

  always_comb begin
    state_d       = state_q;
    pair_d        = pair_q;
    npairs_d      = npairs_q;
    lat_d         = lat_q;
    a_d           = a_q;
    d_d           = d_q;
    rdat_d        = rdat_q;
    rcount_d      = rcount_q;
    err_d         = err_q;
    regs_d        = regs_q;
    wb_start      = 1'b0;
    wb_we         = 1'b0;
    buf_out_arm   = 1'b0;
    buf_in_commit = 1'b0;
    buf_in_wren   = 1'b0;
    case (state_q)
      StIdle: begin
        if (buf_out_hasdata) begin
          pair_d   = '0;
          rcount_d = '0;
          lat_d    = '0;
          npairs_d = buf_out_len[OUT_ADDR_W:1];
          state_d  = (buf_out_len[OUT_ADDR_W:1] == '0) ? StArm : StFetchA;
        end
      end
      StFetchA: begin
        if (lat_q == LatLast) begin
          a_d     = buf_out_q;
          lat_d   = '0;
          state_d = StFetchD;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      StFetchD: begin
        if (lat_q == LatLast) begin
          d_d     = buf_out_q;
          lat_d   = '0;
          state_d = StExec;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      StExec: begin
        if (is_wb_op(op)) begin
          wb_start = 1'b1;
          wb_we    = (op == OP_WB_WR);
          state_d  = StWbWait;
        end else begin
          if (!idx_ok) err_d[2] = 1'b1;
          if (op == OP_LOC_WR) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (idx == 5'(i)) regs_d[i] = d_q;
            end
            state_d = StNext;
          end else begin
            rdat_d  = loc_val;
            state_d = StWrIn;
          end
        end
      end
      StWbWait: begin
        if (wb_done) begin
          if (wb_tmo) err_d[0] = 1'b1;
          if (op == OP_WB_RD) begin
            rdat_d  = wb_rdata;
            state_d = StWrIn;
          end else begin
            state_d = StNext;
          end
        end
      end
      StWrIn: begin
        if (rcount_q[IN_ADDR_W]) begin
          err_d[1] = 1'b1;
        end else begin
          buf_in_wren = 1'b1;
          rcount_d    = rcount_q + 1'b1;
        end
        state_d = StNext;
      end
      StNext: begin
        pair_d  = pair_q + 1'b1;
        state_d = (pair_d == npairs_q) ? StArm : StFetchA;
      end
      StArm: begin
        buf_out_arm = 1'b1;
        if (ack_rise) state_d = (rcount_q != '0) ? StCommit : StIdle;
      end
      StCommit: begin
        buf_in_commit = 1'b1;
        if (buf_in_commit_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pair_q     <= '0;
      npairs_q   <= '0;
      lat_q      <= '0;
      a_q        <= '0;
      d_q        <= '0;
      rdat_q     <= '0;
      rcount_q   <= '0;
      err_q      <= '0;
      regs_q     <= REG_INIT;
      ack_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      pair_q     <= pair_d;
      npairs_q   <= npairs_d;
      lat_q      <= lat_d;
      a_q        <= a_d;
      d_q        <= d_d;
      rdat_q     <= rdat_d;
      rcount_q   <= rcount_d;
      err_q      <= err_d;
      regs_q     <= regs_d;
      ack_sync_q <= {ack_sync_q[1:0], buf_out_arm_ack};
    end
  end

  usb_cmd_wb_master #(
    .WB_ADR_W   (WB_ADR_W),
    .WB_TIMEOUT (WB_TIMEOUT)
  ) u_wb_master (
    .clk       (clk),
    .reset     (reset),
    .start_i   (wb_start),
    .we_i      (wb_we),
    .adr_i     (a_q[WB_ADR_W-1:0]),
    .wdat_i    (d_q),
    .done_o    (wb_done),
    .timeout_o (wb_tmo),
    .rdata_o   (wb_rdata),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_we_o   (wb_we_o),
    .wb_stb_o  (wb_stb_o),
    .wb_ack_i  (wb_ack_i)
  );

  assign buf_out_addr      = ptr_full[OUT_ADDR_W-1:0];
  assign buf_in_addr       = rcount_q[IN_ADDR_W-1:0];
  assign buf_in_data       = rdat_q;
  assign buf_in_commit_len = rcount_q;
  assign regs_out          = regs_q;
  assign busy              = (state_q != StIdle);
  assign err_flags         = err_q;

endmodule

// File: tb/tb_usb_cmd_bridge.sv
// Directed bench for usb_cmd_bridge with an OUT buffer model, IN capture and a wishbone slave.
module tb_usb_cmd_bridge;

  localparam logic [63:0] RegInit = 64'h7A6A5A4A3A2A1A0A;

  logic        clk = 1'b0;
  logic        reset;
  logic        buf_out_hasdata;
  logic [9:0]  buf_out_len;
  logic [7:0]  buf_out_q;
  logic [8:0]  buf_out_addr;
  logic        buf_out_arm;
  logic        buf_out_arm_ack;
  logic [0:0]  buf_in_addr;
  logic [7:0]  buf_in_data;
  logic        buf_in_wren;
  logic        buf_in_commit;
  logic [1:0]  buf_in_commit_len;
  logic        buf_in_commit_ack;
  logic [2:0]  wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat_i;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_ack_i = 1'b0;
  logic [63:0] regs_out;
  logic        busy;
  logic [2:0]  err_flags;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  usb_cmd_bridge #(
    .NUM_REGS   (8),
    .REG_INIT   (RegInit),
    .WB_ADR_W   (3),
    .OUT_ADDR_W (9),
    .IN_ADDR_W  (1),
    .RD_LAT     (4),
    .WB_TIMEOUT (1023)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .buf_out_hasdata   (buf_out_hasdata),
    .buf_out_len       (buf_out_len),
    .buf_out_q         (buf_out_q),
    .buf_out_addr      (buf_out_addr),
    .buf_out_arm       (buf_out_arm),
    .buf_out_arm_ack   (buf_out_arm_ack),
    .buf_in_addr       (buf_in_addr),
    .buf_in_data       (buf_in_data),
    .buf_in_wren       (buf_in_wren),
    .buf_in_commit     (buf_in_commit),
    .buf_in_commit_len (buf_in_commit_len),
    .buf_in_commit_ack (buf_in_commit_ack),
    .wb_adr_o          (wb_adr_o),
    .wb_dat_o          (wb_dat_o),
    .wb_dat_i          (wb_dat_i),
    .wb_we_o           (wb_we_o),
    .wb_stb_o          (wb_stb_o),
    .wb_ack_i          (wb_ack_i),
    .regs_out          (regs_out),
    .busy              (busy),
    .err_flags         (err_flags)
  );

  // OUT buffer: data for an address is valid before the 4th edge after it changes.
  logic [7:0] out_mem [16];
  logic [8:0] d1 = '0, d2 = '0, d3 = '0;
  always @(posedge clk) begin
    d1 <= buf_out_addr;
    d2 <= d1;
    d3 <= d2;
  end
  assign buf_out_q = out_mem[d3[3:0]];

  // IN buffer capture.
  logic [7:0] in_cap [2];
  int in_wr_cnt = 0;
  always @(posedge clk) begin
    if (buf_in_wren) begin
      in_cap[buf_in_addr] <= buf_in_data;
      in_wr_cnt <= in_wr_cnt + 1;
    end
  end

  // Wishbone slave: one-cycle registered ack, fixed read data at address 1.
  logic       slave_en;
  int         slave_wr_cnt = 0;
  int         stb_cnt = 0;
  logic [2:0] last_adr = '0;
  logic [7:0] last_dat = '0;
  assign wb_dat_i = (wb_adr_o == 3'd1) ? 8'h5C : 8'h00;
  always @(posedge clk) begin
    wb_ack_i <= wb_stb_o && !wb_ack_i && slave_en;
    if (wb_stb_o && wb_ack_i && wb_we_o) begin
      last_adr <= wb_adr_o;
      last_dat <= wb_dat_o;
      slave_wr_cnt <= slave_wr_cnt + 1;
    end
  end
  always @(negedge clk) if (wb_stb_o) stb_cnt <= stb_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                      input int len);
    out_mem[0] = b0; out_mem[1] = b1; out_mem[2] = b2;
    out_mem[3] = b3; out_mem[4] = b4; out_mem[5] = b5;
    buf_out_len = 10'(len);
  endtask

  task automatic run_pkt(input bit exp_commit, output logic [1:0] clen);
    int t;
    clen = '0;
    @(negedge clk);
    buf_out_hasdata = 1'b1;
    t = 0;
    while (!busy && t < 20) begin @(negedge clk); t++; end
    buf_out_hasdata = 1'b0;
    t = 0;
    while (!buf_out_arm && t < 3000) begin @(negedge clk); t++; end
    chk("arm_rise", buf_out_arm, 1);
    repeat (5) @(negedge clk);
    chk("arm_hold", buf_out_arm, 1);
    chk("no_commit_before_arm", buf_in_commit, 0);
    buf_out_arm_ack = 1'b1;
    t = 0;
    while (buf_out_arm && t < 10) begin @(negedge clk); t++; end
    chk("arm_drop", buf_out_arm, 0);
    buf_out_arm_ack = 1'b0;
    if (exp_commit) begin
      t = 0;
      while (!buf_in_commit && t < 10) begin @(negedge clk); t++; end
      chk("commit_rise", buf_in_commit, 1);
      clen = buf_in_commit_len;
      buf_in_commit_ack = 1'b1;
      @(negedge clk);
      buf_in_commit_ack = 1'b0;
      chk("commit_drop", buf_in_commit, 0);
    end else begin
      repeat (3) @(negedge clk);
      chk("no_commit", buf_in_commit, 0);
    end
    chk("idle_after_pkt", busy, 0);
  endtask

  initial begin
    logic [1:0] clen;
    int w0, s0, t;
    reset = 1'b1;
    buf_out_hasdata = 1'b0;
    buf_out_len = '0;
    buf_out_arm_ack = 1'b0;
    buf_in_commit_ack = 1'b0;
    slave_en = 1'b1;
    for (int i = 0; i < 16; i++) out_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_regs", regs_out, RegInit);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_flags, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_arm", buf_out_arm, 0);
    chk("rst_commit", buf_in_commit, 0);
    chk("rst_wren", buf_in_wren, 0);
    chk("rst_addr", buf_out_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    // Local write of reg6, no reads so no commit.
    load(8'h86, 8'hF3, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    w0 = in_wr_cnt;
    run_pkt(1'b0, clen);
    chk("t1_reg6", regs_out[55:48], 8'hF3);
    chk("t1_no_in", in_wr_cnt - w0, 0);

    // Wishbone write then read.
    load(8'h03, 8'hA5, 8'h41, 8'h00, 8'h00, 8'h00, 4);
    w0 = slave_wr_cnt;
    run_pkt(1'b1, clen);
    chk("t2_wb_wr_cnt", slave_wr_cnt - w0, 1);
    chk("t2_wb_adr", last_adr, 3'd3);
    chk("t2_wb_dat", last_dat, 8'hA5);
    chk("t2_in0", in_cap[0], 8'h5C);
    chk("t2_clen", clen, 2'd1);

    // Read-after-write within one packet.
    load(8'h81, 8'h11, 8'hC1, 8'h00, 8'hC2, 8'h00, 6);
    run_pkt(1'b1, clen);
    chk("t3_in0", in_cap[0], 8'h11);
    chk("t3_in1", in_cap[1], 8'h2A);
    chk("t3_clen", clen, 2'd2);

    // Wishbone timeout.
    slave_en = 1'b0;
    load(8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    s0 = stb_cnt;
    run_pkt(1'b1, clen);
    chk("t4_stb_cycles", stb_cnt - s0, 1023);
    chk("t4_err", err_flags, 3'b001);
    chk("t4_in0", in_cap[0], 8'hEE);
    chk("t4_clen", clen, 2'd1);
    slave_en = 1'b1;

    // Bad local index and trailing odd byte.
    load(8'h87, 8'h01, 8'h88, 8'h02, 8'hFF, 8'h00, 5);
    w0 = in_wr_cnt;
    run_pkt(1'b0, clen);
    chk("t5_regs", regs_out, 64'h01F35A4A3A2A110A);
    chk("t5_err", err_flags, 3'b101);
    chk("t5_no_in", in_wr_cnt - w0, 0);

    // IN overflow: buffer holds two bytes, third read is dropped.
    load(8'hC0, 8'h00, 8'hC1, 8'h00, 8'hC3, 8'h00, 6);
    w0 = in_wr_cnt;
    run_pkt(1'b1, clen);
    chk("t6_in_writes", in_wr_cnt - w0, 2);
    chk("t6_in0", in_cap[0], 8'h0A);
    chk("t6_in1", in_cap[1], 8'h11);
    chk("t6_clen", clen, 2'd2);
    chk("t6_err", err_flags, 3'b111);

    // Empty packet goes straight to arm.
    load(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    w0 = in_wr_cnt;
    run_pkt(1'b0, clen);
    chk("t7_no_in", in_wr_cnt - w0, 0);

    // Reset while waiting on wishbone.
    slave_en = 1'b0;
    load(8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    buf_out_hasdata = 1'b1;
    t = 0;
    while (!wb_stb_o && t < 200) begin @(negedge clk); t++; end
    chk("t8_stb_before_rst", wb_stb_o, 1);
    buf_out_hasdata = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("t8_stb", wb_stb_o, 0);
    chk("t8_arm", buf_out_arm, 0);
    chk("t8_regs", regs_out, RegInit);
    chk("t8_err", err_flags, 0);
    chk("t8_busy", busy, 0);
    reset = 1'b0;
    slave_en = 1'b1;
    @(negedge clk);
    load(8'h85, 8'h77, 8'hC5, 8'h00, 8'h00, 8'h00, 4);
    run_pkt(1'b1, clen);
    chk("t8_in0", in_cap[0], 8'h77);
    chk("t8_clen", clen, 2'd1);
    chk("t8_reg5", regs_out[47:40], 8'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_cmd_bridge.md
Name: usb_cmd_bridge

Overview:
Generalised USB control-endpoint command engine, sitting between the usb2_top EP2 OUT/IN buffers and the board control plane on clk_50. Each OUT packet carries multiple (address, data) command pairs. Commands write or read NUM_REGS local control registers (reset/select/length style) or a wishbone slave such as opencores_i2c. Read results are gathered into one IN packet committed after the OUT buffer is re-armed.

Parameters:
NUM_REGS, 8, number of local 8-bit control registers (1..32)
REG_INIT, {NUM_REGS{8'h00}}, flattened reset values of the local registers, reg n at bits [8n+7:8n]
WB_ADR_W, 3, wishbone address width (1..5)
OUT_ADDR_W, 9, OUT buffer address width
IN_ADDR_W, 9, IN buffer address width; IN packet holds at most 2**IN_ADDR_W bytes
RD_LAT, 4, cycles from buf_out_addr change to valid buf_out_q
WB_TIMEOUT, 1023, cycles allowed for wb_ack_i before abort

Ports:
clk  in  1  system clock (clk_50 domain)
reset  in  1  asynchronous, active-high reset
buf_out_hasdata  in  1  OUT packet pending
buf_out_len  in  OUT_ADDR_W+1  OUT packet length in bytes
buf_out_q  in  8  OUT buffer read data
buf_out_addr  out  OUT_ADDR_W  OUT buffer read address
buf_out_arm  out  1  release OUT buffer to host
buf_out_arm_ack  in  1  arm acknowledge (may be asynchronous; synchronised internally)
buf_in_addr  out  IN_ADDR_W  IN buffer write address
buf_in_data  out  8  IN buffer write data
buf_in_wren  out  1  IN buffer write strobe
buf_in_commit  out  1  commit IN packet
buf_in_commit_len  out  IN_ADDR_W+1  committed length
buf_in_commit_ack  in  1  commit acknowledge
wb_adr_o  out  WB_ADR_W  wishbone address
wb_dat_o  out  8  wishbone write data
wb_dat_i  in  8  wishbone read data
wb_we_o  out  1  wishbone write enable
wb_stb_o  out  1  wishbone strobe/cycle
wb_ack_i  in  1  wishbone acknowledge
regs_out  out  8*NUM_REGS  local register contents
busy  out  1  engine not in IDLE
err_flags  out  3  sticky: [0] wb timeout, [1] IN overflow, [2] bad local index

Behaviour:
- Reset values: all outputs 0 except regs_out = REG_INIT. Reset mid-packet aborts immediately; OUT is not armed and IN is not committed.
- Command byte A decodes as: A[7:6]=00 wb write to A[WB_ADR_W-1:0], data=D; 01 wb read of A[WB_ADR_W-1:0], D ignored; 10 local write reg A[4:0]=D; 11 local read reg A[4:0].
- An index >= NUM_REGS sets err_flags[2]; a write to it is dropped; a read of it returns 8'hEE.
- Pairs are processed in order for floor(len/2) pairs. A trailing odd byte is ignored. len=0 goes straight to ARM.
- FSM:
  - IDLE: on buf_out_hasdata, clear ptr/rcount and go to FETCH_A.
  - FETCH_A: drive addr=ptr, wait RD_LAT cycles, latch A, then FETCH_D (addr=ptr+1, same wait, latch D), then EXEC.
  - EXEC: local ops take 1 cycle. Wb ops assert stb (we for writes) and go to WB_WAIT.
  - WB_WAIT: on ack, drop stb/we the next cycle and capture wb_dat_i for reads. If the counter reaches WB_TIMEOUT, drop stb, set err[0], and use 8'hEE as read data.
  - A read result is written with a 1-cycle wren at buf_in_addr=rcount, then rcount increments. If rcount = 2**IN_ADDR_W, the write is suppressed and err[1] set.
  - After each pair, ptr += 2; when pairs are exhausted go to ARM.
  - ARM: hold buf_out_arm=1 until a synchronised rising edge of arm_ack (2-flop), then drop it. Go to COMMIT if rcount>0, else IDLE.
  - COMMIT: hold commit=1 with commit_len=rcount until commit_ack, then return to IDLE.
- The OUT buffer is always re-armed before IN is committed; hasdata is ignored outside IDLE.
- Local writes update regs_out the cycle after EXEC. A later pair in the same packet reads the new value.
- err_flags clear only on reset.

Decomposition:
- Shared package usb_cmd_pkg: opcode constants OP_WB_WR/OP_WB_RD/OP_LOC_WR/OP_LOC_RD, FSM state encoding, READ_ERR_BYTE=8'hEE.
- One sub-module, usb_cmd_wb_master: stb/we handshake plus timeout counter, giving a start/done/timeout/rdata interface.

Test Plan:
- OUT {86,F3}, len 2 -> regs_out[55:48]=F3. Arm pulse held until ack; no commit.
- OUT {03,A5,41,00}, len 4 -> wb write adr 3 dat A5, then wb read adr 1 (slave returns 5C). After arm: IN byte0=5C, commit_len=1.
- OUT {81,11,C1,00,C2,00}, len 6 -> IN {11, REG_INIT reg2}, commit_len=2. Read-after-write is ordered.
- Wb slave never acks on OUT {42,00} -> stb dropped after 1023 cycles, err[0]=1, IN {EE}.
- OUT len 5 {87,01,88,02,FF} with NUM_REGS=8 -> reg7=01, err[2]=1, trailing FF ignored, no commit.
- Assert reset during WB_WAIT -> stb=0, arm=0, regs_out=REG_INIT. The next packet is processed normally.
